// File: rtl/instr_issuer.sv
// Sequencer that fetches program words, pulses run_o per instruction and waits for done_i.
// mvi instructions carry a second (immediate) word; halt and watchdog timeout are terminal.
module instr_issuer #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] din_o,
   output logic              run_o,
   input  logic              done_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [7:0]        instr_count_o,
   output logic              halted_o,
   output logic              error_o
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [2:0] OPC_MVI  = 3'b001;
   localparam logic [2:0] OPC_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH_I,
      S_LATCH_D,
      S_ISSUE,
      S_WAIT,
      S_HALT,
      S_ERROR
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] instr_q;
   logic [DATA_W-1:0] imm_q;
   logic [WD_W-1:0]   wdog_q;
   logic [7:0]        count_q;
   logic              run_q;
   logic              halted_q;
   logic              error_q;

   logic              is_mvi;
   logic [ADDR_W-1:0] pc_plus1_d;
   logic [ADDR_W-1:0] pc_done_d;
   logic [WD_W-1:0]   wdog_d;

   assign is_mvi     = (instr_q[2:0] == OPC_MVI);
   assign pc_plus1_d = pc_q + ADDR_W'(1);
   assign pc_done_d  = is_mvi ? (pc_q + ADDR_W'(2)) : pc_plus1_d;
   assign wdog_d     = wdog_q + WD_W'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         mem_addr_q <= '0;
         din_q      <= '0;
         instr_q    <= '0;
         imm_q      <= '0;
         wdog_q     <= '0;
         count_q    <= '0;
         run_q      <= 1'b0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               run_q <= 1'b0;
               if (enable_i) state_q <= S_FETCH;
            end
            S_FETCH: begin
               mem_addr_q <= pc_q;
               state_q    <= S_LATCH_I;
            end
            S_LATCH_I: begin
               instr_q <= mem_data_i;
               if (mem_data_i[2:0] == OPC_HALT) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else if (mem_data_i[2:0] == OPC_MVI) begin
                  // Immediate lives at the following address, wrapping past the top.
                  mem_addr_q <= pc_plus1_d;
                  state_q    <= S_LATCH_D;
               end else begin
                  din_q   <= mem_data_i;
                  run_q   <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_LATCH_D: begin
               imm_q   <= mem_data_i;
               din_q   <= instr_q;
               run_q   <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               run_q   <= 1'b0;
               wdog_q  <= '0;
               din_q   <= is_mvi ? imm_q : instr_q;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (done_i) begin
                  pc_q    <= pc_done_d;
                  count_q <= count_q + 8'd1;
                  state_q <= enable_i ? S_FETCH : S_IDLE;
               end else begin
                  wdog_q <= wdog_d;
                  if (wdog_d == WD_W'(TIMEOUT)) begin
                     error_q <= 1'b1;
                     state_q <= S_ERROR;
                  end
               end
            end
            S_HALT, S_ERROR: begin
               run_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr_o    = mem_addr_q;
   assign din_o         = din_q;
   assign run_o         = run_q;
   assign pc_o          = pc_q;
   assign instr_count_o = count_q;
   assign halted_o      = halted_q;
   assign error_o       = error_q;

endmodule
